div_sqrt_mant_iter: RTL and testbench
=====================================

Name: div_sqrt_mant_iter

Overview:
- Parametrised radix-2 iterative mantissa core for the div/sqrt unit; produces one result bit per cycle.
- Operates on normalised mantissas with the hidden bit, so it supports single (C_MANT=23), double (52), half (10) and bfloat (7) formats.
- Runtime precision control gives early termination.
- Sits between the div/sqrt pre-normaliser (operand mantissas, exponent-parity flag) and the rounding/post-normalisation stage (quotient/root bits plus sticky).

Parameters:
- C_MANT, 23: fraction width without the hidden bit. Operand width is C_MANT+1. Result width C_RES is C_MANT+3.
- C_PREC_W, $clog2(C_MANT+4): width of the precision-control input.

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  asynchronous active-low reset
- Start_SI  in  1  start request; accepted only when Ready_SO=1
- Kill_SI  in  1  abort the current operation
- Sqrt_SI  in  1  mode select: 0 = divide, 1 = square root; sampled at start
- Odd_SI  in  1  sqrt only: exponent odd, so the radicand is pre-shifted left by 1; ignored for divide
- Prec_SI  in  C_PREC_W  result bits to compute; 0 or >C_RES means full C_RES bits
- OpA_DI  in  C_MANT+1  dividend or radicand mantissa; MSB must be 1
- OpB_DI  in  C_MANT+1  divisor mantissa; MSB must be 1; ignored for sqrt
- Ready_SO  out  1  core can accept Start_SI
- Busy_SO  out  1  iteration in progress
- Done_SO  out  1  single-cycle result-valid pulse
- Res_DO  out  C_MANT+3  quotient or root bits, MSB first
- Sticky_SO  out  1  final partial remainder is nonzero

Behaviour:
- Reset (async, Rst_RBI=0): state IDLE, Ready_SO=1, Busy_SO=0, Done_SO=0, Res_DO=0, Sticky_SO=0, all internal registers cleared.
- Function, with A and B as integer mantissas:
  - Divide: Res = floor(A·2^(C_MANT+2)/B).
  - Sqrt: R = Odd ? 2A : A; Res = floor(sqrt(R·2^(C_MANT+4))).
  - Res MSB is the weight-2^(C_MANT+2) bit.
  - Divide result range is [2^(C_MANT+1), 2^(C_MANT+3)). Sqrt result range is [2^(C_MANT+2), 2^(C_MANT+3)).
  - Internal remainder width must be sufficient for both modes with no overflow: C_MANT+4 bits for divide, C_MANT+5 bits for sqrt.
- Precision: N = Prec_SI if 1 ≤ Prec_SI ≤ C_RES, else C_RES.
  - Only the top N bits of Res are computed; the low C_RES−N bits are 0.
  - Sticky_SO = (remainder after N iterations ≠ 0).
- FSM states are IDLE, BUSY and DONE.
  - IDLE: Start_SI=1 → latch operands, mode, Odd and N; go to BUSY with counter=N.
  - BUSY: one result bit per rising edge, counter decrements. On the edge that produces the Nth bit, go to DONE. Busy_SO=1 and Ready_SO=0 throughout BUSY.
  - DONE: lasts exactly one cycle with Done_SO=1 and Ready_SO=1.
    - Start_SI=1 in DONE → straight to BUSY with the new operands (back-to-back operation).
    - Otherwise → IDLE.
- Latency: with Start sampled at edge 0, iterations occur at edges 1..N and Done_SO is high during the cycle after edge N. Total latency is N+1 edges.
- Result hold: Res_DO and Sticky_SO are stable from DONE until the next accepted Start. They are not cleared on entering IDLE.
- Start_SI while BUSY is ignored: no effect, no queuing.
- Kill_SI has priority over everything, including Start_SI in the same cycle.
  - Next state is IDLE, with no Done pulse and the counter cleared.
  - Res_DO and Sticky_SO are cleared to 0.
  - Kill_SI in IDLE is harmless.
- Reset asserted mid-operation behaves identically to Kill_SI, but asynchronously.
- Operand changes after the Start edge do not affect the running operation.
- MSB=0 operands are illegal; the result is undefined, but the FSM timing is unchanged.

Test Plan (C_MANT=23):
1. Divide 1.0/1.0: A=B=0x800000, Prec=0 → Done_SO high 27 edges after Start (N=26); Res=0x2000000; Sticky=0.
2. Divide 1/3: A=0x800000, B=0xC00000 → Res=0x1555555, Sticky=1.
3. Divide 1/3 with Prec=8 → Res=0x1540000, Sticky=1, Done_SO after 9 edges. Repeat with Prec=31 → full 26-bit result.
4. Sqrt: A=0x800000 with Odd=0 → Res=0x2000000, Sticky=0. A=0x800000 with Odd=1 → Res=0x2D413CC, Sticky=1.
5. Back-to-back and ignored start:
   - Assert Start in the DONE cycle with A=0xC00000, B=0x800000 → no IDLE gap; second Res=0x3000000.
   - Start pulses during BUSY → ignored, results unchanged.
6. Kill and reset:
   - Kill at iteration 10 together with Start=1 → IDLE next cycle, no Done_SO, Res=0, Ready_SO=1.
   - Async reset mid-BUSY → all outputs at reset values immediately.
   - A subsequent normal divide completes correctly.

Source files
------------

// File: rtl/div_sqrt_mant_iter.sv
// Radix-2 restoring mantissa divider / square-root core, one result bit per cycle.
// Latency N+1 edges (N = effective precision); Start is ignored while busy and Kill aborts at once.
module div_sqrt_mant_iter #(
    parameter int C_MANT   = 23,
    parameter int C_PREC_W = $clog2(C_MANT+4)
) (
    input  logic                Clk_CI,
    input  logic                Rst_RBI,
    input  logic                Start_SI,
    input  logic                Kill_SI,
    input  logic                Sqrt_SI,
    input  logic                Odd_SI,
    input  logic [C_PREC_W-1:0] Prec_SI,
    input  logic [C_MANT:0]     OpA_DI,
    input  logic [C_MANT:0]     OpB_DI,
    output logic                Ready_SO,
    output logic                Busy_SO,
    output logic                Done_SO,
    output logic [C_MANT+2:0]   Res_DO,
    output logic                Sticky_SO
);

    localparam int C_RES = C_MANT + 3;
    localparam int C_REM = C_MANT + 6;
    localparam int C_RAD = C_MANT + 2;
    localparam logic [C_PREC_W-1:0] C_RES_P = C_PREC_W'(C_RES);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e                state_q, state_d;
    logic                  sqrt_q, sqrt_d;
    logic [C_MANT:0]       opb_q, opb_d;
    logic [C_RAD-1:0]      rad_q, rad_d;
    logic [C_REM-1:0]      rem_q, rem_d;
    logic [C_RES-1:0]      part_q, part_d;
    logic [C_RES-1:0]      res_q, res_d;
    logic                  sticky_q, sticky_d;
    logic [C_PREC_W-1:0]   cnt_q, cnt_d;
    logic [C_PREC_W-1:0]   n_q, n_d;

    logic [C_PREC_W-1:0]   prec_n;
    logic [C_PREC_W-1:0]   shamt;
    logic [C_REM-1:0]      cur, trial, sub;
    logic                  ge;
    logic [C_RES-1:0]      iter_part;
    logic                  accept;

    // One recurrence step; sqrt brings down the next radicand bit pair each cycle.
    always_comb begin
        prec_n = (Prec_SI == '0 || Prec_SI > C_RES_P) ? C_RES_P : Prec_SI;
        if (sqrt_q) begin
            cur   = {rem_q[C_REM-3:0], rad_q[C_RAD-1 -: 2]};
            trial = C_REM'({part_q, 2'b01});
        end else begin
            cur   = rem_q;
            trial = C_REM'(opb_q);
        end
        ge        = (cur >= trial);
        sub       = ge ? (cur - trial) : cur;
        iter_part = {part_q[C_RES-2:0], ge};
        shamt     = C_RES_P - n_q;
    end

    assign accept = Start_SI && !Kill_SI && (state_q != S_BUSY);

    always_comb begin
        state_d  = state_q;
        sqrt_d   = sqrt_q;
        opb_d    = opb_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        part_d   = part_q;
        res_d    = res_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        n_d      = n_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_BUSY;
                    sqrt_d  = Sqrt_SI;
                    opb_d   = OpB_DI;
                    rad_d   = Odd_SI ? {OpA_DI, 1'b0} : {1'b0, OpA_DI};
                    rem_d   = Sqrt_SI ? '0 : C_REM'(OpA_DI);
                    part_d  = '0;
                    cnt_d   = prec_n;
                    n_d     = prec_n;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                part_d = iter_part;
                cnt_d  = cnt_q - 1'b1;
                if (sqrt_q) begin
                    rem_d = sub;
                    rad_d = {rad_q[C_RAD-3:0], 2'b00};
                end else begin
                    rem_d = {sub[C_REM-2:0], 1'b0};
                end
                if (cnt_q == C_PREC_W'(1)) begin
                    state_d  = S_DONE;
                    res_d    = iter_part << shamt;
                    sticky_d = (sub != '0);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (Kill_SI) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            res_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q  <= S_IDLE;
            sqrt_q   <= 1'b0;
            opb_q    <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            part_q   <= '0;
            res_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            n_q      <= '0;
        end else begin
            state_q  <= state_d;
            sqrt_q   <= sqrt_d;
            opb_q    <= opb_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            part_q   <= part_d;
            res_q    <= res_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
        end
    end

    assign Ready_SO  = (state_q != S_BUSY);
    assign Busy_SO   = (state_q == S_BUSY);
    assign Done_SO   = (state_q == S_DONE);
    assign Res_DO    = res_q;
    assign Sticky_SO = sticky_q;

endmodule

// File: tb/tb_div_sqrt_mant_iter.sv
// Directed bench for div_sqrt_mant_iter (C_MANT=23): divide, sqrt, precision, back-to-back, kill, reset.
module tb_div_sqrt_mant_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic        sq;
    logic        odd;
    logic [4:0]  prec;
    logic [23:0] opa;
    logic [23:0] opb;
    logic        ready;
    logic        busy;
    logic        done;
    logic [25:0] res;
    logic        sticky;

    int total = 0;
    int bad   = 0;

    div_sqrt_mant_iter #(.C_MANT(23)) dut (
        .Clk_CI    (clk),
        .Rst_RBI   (rst_n),
        .Start_SI  (start),
        .Kill_SI   (kill),
        .Sqrt_SI   (sq),
        .Odd_SI    (odd),
        .Prec_SI   (prec),
        .OpA_DI    (opa),
        .OpB_DI    (opb),
        .Ready_SO  (ready),
        .Busy_SO   (busy),
        .Done_SO   (done),
        .Res_DO    (res),
        .Sticky_SO (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; Start is seen at the next posedge, returns at the negedge after it.
    task automatic launch(input logic s, input logic o, input logic [4:0] p,
                          input logic [23:0] a, input logic [23:0] b);
        sq = s; odd = o; prec = p; opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        opa = 24'h0;
        opb = 24'h0;
    endtask

    task automatic wait_done(input int init, output int lat);
        lat = init;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic s, input logic o, input logic [4:0] p,
                      input logic [23:0] a, input logic [23:0] b,
                      input logic [25:0] er, input logic es, input int el);
        int lat;
        @(negedge clk);
        launch(s, o, p, a, b);
        wait_done(1, lat);
        check({tag, ".lat"}, lat, el);
        check({tag, ".res"}, res, er);
        check({tag, ".sticky"}, sticky, es);
        check({tag, ".ready"}, ready, 1'b1);
    endtask

    initial begin
        int lat;
        int nd;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; sq = 1'b0; odd = 1'b0;
        prec = 5'd0; opa = 24'h0; opb = 24'h0;
        #12;
        check("rst.ready",  ready,  1'b1);
        check("rst.busy",   busy,   1'b0);
        check("rst.done",   done,   1'b0);
        check("rst.res",    res,    26'h0);
        check("rst.sticky", sticky, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op("div1_1",    0, 0, 5'd0,  24'h800000, 24'h800000, 26'h2000000, 1'b0, 27);
        op("div1_3",    0, 0, 5'd0,  24'h800000, 24'hC00000, 26'h1555555, 1'b1, 27);
        op("div1_3p8",  0, 0, 5'd8,  24'h800000, 24'hC00000, 26'h1540000, 1'b1, 9);
        op("div1_3p31", 0, 0, 5'd31, 24'h800000, 24'hC00000, 26'h1555555, 1'b1, 27);
        op("div1_3p27", 0, 0, 5'd27, 24'h800000, 24'hC00000, 26'h1555555, 1'b1, 27);
        op("div1_3p1",  0, 0, 5'd1,  24'h800000, 24'hC00000, 26'h0000000, 1'b1, 2);
        op("divmax",    0, 0, 5'd0,  24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 27);
        op("sqrt_even", 1, 0, 5'd0,  24'h800000, 24'h000000, 26'h2000000, 1'b0, 27);

        repeat (3) @(negedge clk);
        check("hold.res",  res,  26'h2000000);
        check("hold.done", done, 1'b0);

        op("sqrt_odd",  1, 1, 5'd0,  24'h800000, 24'h000000, 26'h2D413CC, 1'b1, 27);
        // Back-to-back: Start issued during the Done cycle.
        launch(0, 0, 5'd0, 24'hC00000, 24'h800000);
        check("b2b.busy", busy, 1'b1);
        wait_done(1, lat);
        check("b2b.lat",    lat,    27);
        check("b2b.res",    res,    26'h3000000);
        check("b2b.sticky", sticky, 1'b0);

        @(negedge clk);
        launch(0, 0, 5'd0, 24'h800000, 24'hC00000);
        repeat (3) begin
            start = 1'b1; sq = 1'b1; opa = 24'hFFFFFF; opb = 24'h800000;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(4, lat);
        check("ign.lat",    lat,    27);
        check("ign.res",    res,    26'h1555555);
        check("ign.sticky", sticky, 1'b1);

        @(negedge clk);
        launch(0, 0, 5'd0, 24'h800000, 24'hC00000);
        repeat (9) @(negedge clk);
        kill = 1'b1; start = 1'b1; opa = 24'h800000; opb = 24'h800000;
        @(negedge clk);
        kill = 1'b0; start = 1'b0;
        check("kill.ready",  ready,  1'b1);
        check("kill.busy",   busy,   1'b0);
        check("kill.done",   done,   1'b0);
        check("kill.res",    res,    26'h0);
        check("kill.sticky", sticky, 1'b0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("kill.nodone", nd, 0);

        op("pre_rst", 0, 0, 5'd0, 24'h800000, 24'hC00000, 26'h1555555, 1'b1, 27);
        @(negedge clk);
        launch(0, 0, 5'd0, 24'h800000, 24'hC00000);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.ready",  ready,  1'b1);
        check("arst.busy",   busy,   1'b0);
        check("arst.done",   done,   1'b0);
        check("arst.res",    res,    26'h0);
        check("arst.sticky", sticky, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op("post_rst", 0, 0, 5'd0, 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
